// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//
// Front-end fetch stage. Holds the fetch PC, issues one aligned 16-byte
// I-cache request at a time and splits each response into up to four
// {pc, instr} entries for the instruction buffer. Requests are gated on
// instruction-buffer free space. Redirects flush the buffer, retarget the PC
// and discard any response still in flight for the old path.
//
// Optional feature: define IF_PERF_CNT_EN to build the two performance
// counters; otherwise both perf outputs are tied to 0.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   redirect_valid/pc   back-end redirect request and target
//   ib_size             current instruction-buffer occupancy
//   icache_req_*        request channel (valid/ready/aligned address)
//   icache_resp_*       response channel (always accepted), 4 x 32-bit words
//   if1_to_ib           4 packed {pc, instr} entries, slot 0 in the LSBs
//   push_num            number of valid slots (0..4)
//   flush_ib            clear the instruction buffer (same cycle as redirect)
//   perf_stall_cycles   cycles in REQ blocked by buffer space
//   perf_fetch_pkts     cycles with a non-zero push
// ---------------------------------------------------------------------------
module if_fetch_stage #(
  parameter int          IB_WIDTH      = 16,
  parameter int          IB_WIDTH_LOG2 = 4,
  parameter logic [31:0] RESET_PC      = 32'h1c00_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  input  logic [IB_WIDTH_LOG2:0]   ib_size,
  output logic                     icache_req_valid,
  input  logic                     icache_req_ready,
  output logic [31:0]              icache_req_addr,
  input  logic                     icache_resp_valid,
  input  logic [127:0]             icache_resp_data,
  output logic [255:0]             if1_to_ib,
  output logic [2:0]               push_num,
  output logic                     flush_ib,
  output logic [31:0]              perf_stall_cycles,
  output logic [31:0]              perf_fetch_pkts
);

  localparam logic [1:0] ST_REQ     = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  // A full packet of four entries must fit before a request is issued.
  localparam logic [IB_WIDTH_LOG2:0] SPACE_MAX = (IB_WIDTH_LOG2 + 1)'(IB_WIDTH - 4);

  logic [31:0] pc;
  logic [1:0]  state;
  logic        space_ok;
  logic        push_fire;
  logic [31:0] fetch_base;
  logic [1:0]  ofs;

  // Only word-aligned PCs are supported, so the byte offset is never used.
  logic unused_pc_bits;
  assign unused_pc_bits = ^pc[1:0];

  assign space_ok   = (ib_size <= SPACE_MAX);
  assign fetch_base = {pc[31:4], 4'b0};
  assign ofs        = pc[3:2];

  assign flush_ib         = redirect_valid;
  assign icache_req_addr  = fetch_base;
  // Held low during reset so every output except the address reads 0.
  assign icache_req_valid = ~rst & (state == ST_REQ) & space_ok & ~redirect_valid;
  assign push_fire        = (state == ST_WAIT) & icache_resp_valid & ~redirect_valid;

  // Split the response starting at the word the PC points into.
  always_comb begin : split_resp
    logic [2:0] idx;
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned (which would infer a latch).
    if1_to_ib = '0;
    push_num  = '0;
    idx       = '0;
    if (push_fire) begin
      push_num = 3'd4 - {1'b0, ofs};
      for (int i = 0; i < 4; i++) begin
        idx = {1'b0, ofs} + 3'(i);
        if (idx < 3'd4) begin
          if1_to_ib[64*i +: 64] = {fetch_base + {27'b0, idx, 2'b00},
                                   icache_resp_data[{idx[1:0], 5'b0} +: 32]};
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together from pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= RESET_PC;
      state <= ST_REQ;
    end else if (redirect_valid) begin
      pc <= redirect_pc;
      // A request still in flight must have its response swallowed; if it
      // arrives this very cycle it is dropped here instead.
      if (state == ST_REQ || icache_resp_valid) state <= ST_REQ;
      else                                      state <= ST_DISCARD;
    end else begin
      case (state)
        ST_REQ: begin
          if (icache_req_valid && icache_req_ready) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (icache_resp_valid) begin
            pc    <= {pc[31:4] + 28'd1, 4'b0};
            state <= ST_REQ;
          end
        end
        ST_DISCARD: begin
          if (icache_resp_valid) state <= ST_REQ;
        end
        default: state <= ST_REQ;
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] pkt_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      pkt_cnt   <= '0;
    end else begin
      if (state == ST_REQ && !space_ok && !redirect_valid) stall_cnt <= stall_cnt + 32'd1;
      if (push_num != 3'd0)                                pkt_cnt   <= pkt_cnt + 32'd1;
    end
  end

  assign perf_stall_cycles = stall_cnt;
  assign perf_fetch_pkts   = pkt_cnt;
`else
  assign perf_stall_cycles = '0;
  assign perf_fetch_pkts   = '0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage
//
// Directed testbench for if_fetch_stage. Inputs change 1 time unit after the
// rising edge; outputs are checked 2 units later, well before the next edge.
// Performance-counter expectations follow IF_PERF_CNT_EN when it is defined
// for the build.
// ---------------------------------------------------------------------------
module tb_if_fetch_stage;

`ifdef IF_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic [4:0]   ib_size;
  logic         icache_req_valid;
  logic         icache_req_ready;
  logic [31:0]  icache_req_addr;
  logic         icache_resp_valid;
  logic [127:0] icache_resp_data;
  logic [255:0] if1_to_ib;
  logic [2:0]   push_num;
  logic         flush_ib;
  logic [31:0]  perf_stall_cycles;
  logic [31:0]  perf_fetch_pkts;

  int n_checks = 0;
  int n_fails  = 0;

  if_fetch_stage #(
    .IB_WIDTH      (16),
    .IB_WIDTH_LOG2 (4),
    .RESET_PC      (32'h1c00_0000)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .ib_size           (ib_size),
    .icache_req_valid  (icache_req_valid),
    .icache_req_ready  (icache_req_ready),
    .icache_req_addr   (icache_req_addr),
    .icache_resp_valid (icache_resp_valid),
    .icache_resp_data  (icache_resp_data),
    .if1_to_ib         (if1_to_ib),
    .push_num          (push_num),
    .flush_ib          (flush_ib),
    .perf_stall_cycles (perf_stall_cycles),
    .perf_fetch_pkts   (perf_fetch_pkts)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] slot(input int i);
    return if1_to_ib[64*i +: 64];
  endfunction

  function automatic logic [31:0] stall_exp(input int n);
    return PERF_EN ? 32'(n) : 32'd0;
  endfunction

  initial begin
    rst               = 1'b1;
    redirect_valid    = 1'b0;
    redirect_pc       = '0;
    ib_size           = 5'd0;
    icache_req_ready  = 1'b1;
    icache_resp_valid = 1'b0;
    icache_resp_data  = '0;

    // Reset state.
    #2;
    check("rst_valid", icache_req_valid, 0);
    check("rst_addr",  icache_req_addr, 32'h1c00_0000);
    check("rst_push",  push_num, 0);
    check("rst_flush", flush_ib, 0);
    check("rst_slots", {32'h0, if1_to_ib[31:0]} | if1_to_ib[255:192], 0);
    check("rst_stall", perf_stall_cycles, 0);
    check("rst_pkts",  perf_fetch_pkts, 0);

    // First fetch after reset release (mid-cycle).
    #10;
    rst = 1'b0;
    #1;
    check("first_valid", icache_req_valid, 1);
    check("first_addr",  icache_req_addr, 32'h1c00_0000);
    tick();  // handshake -> WAIT
    check("wait_valid", icache_req_valid, 0);
    icache_resp_valid = 1'b1;
    icache_resp_data  = {32'hdddd_0004, 32'hcccc_0003, 32'hbbbb_0002, 32'haaaa_0001};
    #2;
    check("full_push", push_num, 4);
    check("full_s0", slot(0), {32'h1c00_0000, 32'haaaa_0001});
    check("full_s1", slot(1), {32'h1c00_0004, 32'hbbbb_0002});
    check("full_s2", slot(2), {32'h1c00_0008, 32'hcccc_0003});
    check("full_s3", slot(3), {32'h1c00_000c, 32'hdddd_0004});
    tick();
    icache_resp_valid = 1'b0;
    ib_size           = 5'd4;
    #2;
    check("next_valid", icache_req_valid, 1);
    check("next_addr",  icache_req_addr, 32'h1c00_0010);
    check("pkts_1",     perf_fetch_pkts, PERF_EN ? 32'd1 : 32'd0);

    // Redirect while in REQ to an unaligned-in-line target.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h1c00_0108;
    #2;
    check("rq_redir_flush", flush_ib, 1);
    check("rq_redir_valid", icache_req_valid, 0);
    check("rq_redir_push",  push_num, 0);
    tick();
    redirect_valid = 1'b0;
    #2;
    check("rq_after_flush", flush_ib, 0);
    check("rq_after_valid", icache_req_valid, 1);
    check("rq_after_addr",  icache_req_addr, 32'h1c00_0100);
    tick();  // handshake -> WAIT
    icache_resp_valid = 1'b1;
    icache_resp_data  = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
    #2;
    check("part_push", push_num, 2);
    check("part_s0", slot(0), {32'h1c00_0108, 32'h3333_0002});
    check("part_s1", slot(1), {32'h1c00_010c, 32'h4444_0003});
    check("part_s2", slot(2), 0);
    check("part_s3", slot(3), 0);
    tick();
    icache_resp_valid = 1'b0;

    // Buffer too full: ib_size 13 blocks, 12 lets the request through.
    ib_size = 5'd13;
    for (int i = 1; i <= 3; i++) begin
      #2;
      check("full_ib_valid", icache_req_valid, 0);
      tick();
      check("stall_cnt", perf_stall_cycles, stall_exp(i));
    end
    ib_size = 5'd12;
    #1;
    check("space_valid", icache_req_valid, 1);
    check("space_addr",  icache_req_addr, 32'h1c00_0110);
    check("stall_hold",  perf_stall_cycles, stall_exp(3));
    check("pkts_2",      perf_fetch_pkts, PERF_EN ? 32'd2 : 32'd0);
    tick();  // handshake -> WAIT

    // Redirect in WAIT, stale response two cycles later.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h1c00_0200;
    #2;
    check("wt_redir_flush", flush_ib, 1);
    check("wt_redir_push",  push_num, 0);
    tick();  // -> DISCARD
    redirect_valid = 1'b0;
    #2;
    check("disc_flush", flush_ib, 0);
    check("disc_valid", icache_req_valid, 0);
    tick();
    icache_resp_valid = 1'b1;
    icache_resp_data  = {4{32'hdead_beef}};
    #2;
    check("disc_push",  push_num, 0);
    check("disc_slots", slot(0), 0);
    tick();
    icache_resp_valid = 1'b0;
    #2;
    check("disc_next_valid", icache_req_valid, 1);
    check("disc_next_addr",  icache_req_addr, 32'h1c00_0200);
    tick();  // handshake -> WAIT

    // Redirect coincident with a response.
    icache_resp_valid = 1'b1;
    redirect_valid    = 1'b1;
    redirect_pc       = 32'h1c00_0304;
    #2;
    check("coin_push",  push_num, 0);
    check("coin_flush", flush_ib, 1);
    tick();
    icache_resp_valid = 1'b0;
    redirect_valid    = 1'b0;
    #2;
    check("coin_valid", icache_req_valid, 1);
    check("coin_addr",  icache_req_addr, 32'h1c00_0300);
    check("pkts_hold",  perf_fetch_pkts, PERF_EN ? 32'd2 : 32'd0);

    // Request held while the cache is not ready.
    icache_req_ready = 1'b0;
    tick();
    #2;
    check("hold_valid", icache_req_valid, 1);
    check("hold_addr",  icache_req_addr, 32'h1c00_0300);
    icache_req_ready = 1'b1;
    tick();  // handshake -> WAIT
    #1;
    check("wait2_valid", icache_req_valid, 0);

    // Asynchronous reset while in WAIT.
    rst = 1'b1;
    #1;
    check("arst_addr",  icache_req_addr, 32'h1c00_0000);
    check("arst_valid", icache_req_valid, 0);
    check("arst_push",  push_num, 0);
    check("arst_stall", perf_stall_cycles, 0);
    check("arst_pkts",  perf_fetch_pkts, 0);
    tick();
    #2;
    rst = 1'b0;
    #1;
    check("post_valid", icache_req_valid, 1);
    check("post_addr",  icache_req_addr, 32'h1c00_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Front-end fetch stage driving the instruction buffer. It holds the fetch PC, issues one aligned 16-byte I-cache request at a time, and splits each response into up to four {pc, instr} entries with a push count. It gates requests on buffer free space and handles branch/exception redirects, including discarding stale in-flight responses.

## Interface
Parameters:
- `IB_WIDTH`, 16: instruction-buffer depth in entries (power of two, ≥ 8).
- `IB_WIDTH_LOG2`, 4: log2 of `IB_WIDTH`.
- `RESET_PC`, 32'h1c00_0000: fetch PC after reset.

Ports (entry format is {pc[31:0], instr[31:0]}, 64 bits):
- `clk`  in  1  clock; one clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `redirect_valid`  in  1  redirect request from the back end.
- `redirect_pc`  in  32  redirect target.
- `ib_size`  in  IB_WIDTH_LOG2+1  current instruction-buffer occupancy.
- `icache_req_valid`  out  1  request valid.
- `icache_req_ready`  in  1  cache accepts the request.
- `icache_req_addr`  out  32  {pc[31:4], 4'b0}.
- `icache_resp_valid`  in  1  response valid; always accepted.
- `icache_resp_data`  in  128  word k is `data[32k+31:32k]`.
- `if1_to_ib`  out  4×64  packed entries; slot 0 is in the LSBs.
- `push_num`  out  3  number of valid slots, 0–4.
- `flush_ib`  out  1  clear the instruction buffer.
- `perf_stall_cycles`  out  32  performance counter (see Configuration).
- `perf_fetch_pkts`  out  32  performance counter (see Configuration).

## Operation
Registers:
- `pc[31:0]`: only `pc[1:0]==0` is supported.
- `state`: one of `REQ`, `WAIT`, `DISCARD`.

Free-space gate:
- `space_ok = (ib_size <= IB_WIDTH-4)`.
- `ib_size` is computed as IB_WIDTH_LOG2+1 bits; no overflow is possible.

State `REQ`:
- `icache_req_valid = space_ok & ~redirect_valid`.
- On handshake (valid & ready) → `WAIT`.

State `WAIT`:
- `icache_req_valid = 0`.
- On `icache_resp_valid`, with `o = pc[3:2]`:
  - `push_num = 4 - o`.
  - Slot i < `push_num` = {{pc[31:4], 4'b0} + 4·(o+i), word[o+i]}.
  - Unused slots are driven to 0.
  - `pc <= {pc[31:4]+1, 4'b0}`; state → `REQ`.

State `DISCARD`:
- A stale response is outstanding.
- The next `icache_resp_valid` is dropped (`push_num = 0`); state → `REQ`.

Redirect (`redirect_valid = 1`) has priority over all other events:
- `flush_ib = 1`, `push_num = 0`, `icache_req_valid = 0` in that cycle.
- `pc <= redirect_pc`.
- Next state:
  - From `REQ` → `REQ`.
  - From `WAIT` with no response this cycle → `DISCARD`.
  - From `WAIT` with a response this cycle → `REQ`; the response is dropped.
  - From `DISCARD` with no response this cycle → `DISCARD`.
  - From `DISCARD` with a response this cycle → `REQ`.
- `flush_ib` is combinational: `flush_ib = redirect_valid`.

Other rules:
- `push_num` is nonzero only in the cycle a response is accepted in `WAIT` without a redirect.
- At most one request is outstanding.
- The cache must never return a response without a prior handshake; otherwise behaviour is undefined.

## Timing
- Reset values:
  - `pc = RESET_PC`, `state = REQ`.
  - All outputs 0, except `icache_req_addr = {RESET_PC[31:4], 4'b0}`.
  - Counters are 0.
- `rst` asserted mid-operation: immediate return to reset values. A response from a pre-reset request that arrives after reset is not filtered; the cache must be reset together with this block.
- Latency:
  - Request handshake at cycle t → earliest response at t+1.
  - Entries are pushed in the response cycle (combinational from the response).
  - Next request at the earliest in the cycle after the response. By then `ib_size` already includes the push.
- `icache_req_addr` and `icache_req_valid` are stable while valid & ~ready. They change only on redirect, which withdraws valid.

## Configuration
- `IF_PERF_CNT_EN` defined:
  - `perf_stall_cycles` increments every cycle in `REQ` with `~space_ok & ~redirect_valid`.
  - `perf_fetch_pkts` increments every cycle with `push_num != 0`.
  - Both are 32-bit and wrap; both are cleared by `rst` only.
- Not defined: both outputs are tied to 0 and no counter flops exist.

## Test plan
- Reset with `ib_size=0`, `ready=1`:
  - `icache_req_addr=0x1c000000` in the first cycle.
  - Response {D,C,B,A} → `push_num=4`; slots {0x1c000000,A} … {0x1c00000c,D}.
  - Next request address 0x1c000010.
- Redirect to 0x1c000108 in `REQ`:
  - Next request address 0x1c000100.
  - Response → `push_num=2`; slots {0x1c000108, word2} and {0x1c00010c, word3}.
- `ib_size=13` (IB_WIDTH=16):
  - `icache_req_valid` stays 0 and `perf_stall_cycles` increments each cycle (with macro).
  - Dropping `ib_size` to 12 → request issued the same cycle.
- Redirect in `WAIT` with the response 2 cycles later:
  - `flush_ib=1` for exactly one cycle.
  - The late response yields `push_num=0`.
  - The following request is to the redirect target.
- Redirect coincident with a response:
  - That response is dropped and state returns to `REQ`.
  - The next request is to the target the cycle after.
- Assert `rst` while in `WAIT`:
  - Outputs return to reset values asynchronously.
  - After release, the first request is to 0x1c000000.
